// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and reports read data, slave error and timeout on a single-cycle response pulse.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// ERRRSP | misaligned command, error response without APB activity
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERRRSP = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cmd_ready_d;
    logic        psel_d, penable_d, pwrite_d;
    logic [31:0] paddr_d, pwdata_d;
    logic        rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [31:0] rsp_rdata_d;

    // Every output is registered, so no APB input reaches an APB output combinationally.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready   <= cmd_ready_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = rsp_rdata;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_d     = ERRRSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        pwdata_d  = cmd_write ? cmd_wdata : 32'd0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite ? 32'd0 : prdata;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ERRRSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

endmodule
